// File: rtl/hex_digit_sched_pkg.sv
// rtl/hex_digit_sched_pkg.sv - shared encodings and segment table for the digit scheduler
package hex_digit_sched_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_LOAD   = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FULL   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segments, index is the nibble value 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational nibble to active-low seven-segment decoder with blanking
module hex7seg
    import hex_digit_sched_pkg::*;
#(
    parameter logic [6:0] BLANK = SEG_BLANK
) (
    input  logic [3:0] value,
    input  logic       valid,
    output logic [6:0] seg
);

    assign seg = valid ? seg_lookup(value) : BLANK;

endmodule

// File: rtl/hex_digit_sched.sv
// rtl/hex_digit_sched.sv - six-slot digit buffer with load/scroll/clear onto HEX5..HEX0
module hex_digit_sched
    import hex_digit_sched_pkg::*;
#(
    parameter int         NUM_DIGITS = 6,
    parameter logic [6:0] BLANK      = SEG_BLANK
) (
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam logic [2:0] N3   = 3'(NUM_DIGITS);
    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] data;
    logic       unused_sw;

    assign clk       = KEY[0];
    assign rst_n     = KEY[1];
    assign mode      = SW[9:8];
    assign data      = SW[3:0];
    assign unused_sw = ^SW[7:4];

    logic [3:0]            digit_buf [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] valid;
    logic [2:0]            cnt;
    logic [2:0]            rot;
    logic                  ovf;
    state_t                state, state_nxt;
    logic                  cnt_full;

    assign cnt_full = (cnt == N3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (mode)
            MODE_CLEAR:  state_nxt = ST_IDLE;
            // Reaching or already at capacity lands in FULL; any load ends a scroll
            MODE_LOAD:   state_nxt = (cnt_full || cnt == LAST) ? ST_FULL : ST_IDLE;
            MODE_SCROLL: if (cnt != 3'd0) state_nxt = ST_SCROLL;
            default:     if (state == ST_SCROLL) state_nxt = cnt_full ? ST_FULL : ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= 4'd0;
            valid <= '0;
            cnt   <= 3'd0;
            rot   <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            case (mode)
                MODE_CLEAR: begin
                    for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= 4'd0;
                    valid <= '0;
                    cnt   <= 3'd0;
                    rot   <= 3'd0;
                    ovf   <= 1'b0;
                end
                MODE_LOAD: begin
                    if (!cnt_full) begin
                        digit_buf[cnt] <= data;
                        valid[cnt]     <= 1'b1;
                        cnt            <= cnt + 3'd1;
                    end else begin
                        ovf <= 1'b1;
                    end
                end
                MODE_SCROLL: begin
                    if (cnt != 3'd0) rot <= (rot == LAST) ? 3'd0 : rot + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Position p (HEX5 = p0) shows physical slot (p + rot) mod NUM_DIGITS
    logic [6:0] seg [6];

    for (genvar p = 0; p < 6; p++) begin : g_pos
        if (p < NUM_DIGITS) begin : g_live
            logic [3:0] sum;
            logic [2:0] slot;
            assign sum  = 4'(p) + {1'b0, rot};
            assign slot = (sum >= 4'(NUM_DIGITS)) ? 3'(sum - 4'(NUM_DIGITS)) : sum[2:0];
            hex7seg #(.BLANK(BLANK)) u_seg (
                .value (digit_buf[slot]),
                .valid (valid[slot]),
                .seg   (seg[p])
            );
        end else begin : g_off
            assign seg[p] = BLANK;
        end
    end

    assign HEX5 = seg[0];
    assign HEX4 = seg[1];
    assign HEX3 = seg[2];
    assign HEX2 = seg[3];
    assign HEX1 = seg[4];
    assign HEX0 = seg[5];

    assign LEDR = {(state == ST_FULL) || cnt_full, ovf, state == ST_SCROLL, 4'b0000, cnt};

endmodule
